quake_sample_ctrl: RTL

//  Sequencer for the accelerometer scaling datapath. It issues periodic sample requests to the sensor reader
//  and latches the raw X/Y/Z words onto the scaler inputs. After the scaler pipeline latency it captures the

---
 rtl/quake_sample_ctrl_if.sv | 34 +++
 rtl/quake_sample_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/quake_sample_ctrl_if.sv
// rtl/quake_sample_ctrl_if.sv - sensor reader request/ack handshake bundle
//
// Purpose: carries the sample request and the one-cycle acknowledge with the
// raw X/Y/Z words between the sample controller and the sensor reader.
// Signals:
//   sens_req  controller -> reader  request a sample
//   sens_ack  reader -> controller  one-cycle ack, data valid this cycle
//   xdata     reader -> controller  raw X word (16)
//   ydata     reader -> controller  raw Y word (16)
//   zdata     reader -> controller  raw Z word (16)
// Modports: master = controller side, slave = sensor reader side.
interface quake_sample_ctrl_if;
  logic        sens_req;
  logic        sens_ack;
  logic [15:0] xdata;
  logic [15:0] ydata;
  logic [15:0] zdata;

  modport master (
    output sens_req,
    input  sens_ack,
    input  xdata,
    input  ydata,
    input  zdata
  );

  modport slave (
    input  sens_req,
    output sens_ack,
    output xdata,
    output ydata,
    output zdata
  );
endinterface

// File: rtl/quake_sample_ctrl.sv
// rtl/quake_sample_ctrl.sv - accelerometer sample sequencer with peak/threshold alarm
//
// Purpose: issues periodic sample requests, latches raw X/Y/Z onto the scaler
// inputs, captures the scaled magnitudes after the scaler latency, reduces them
// to a peak and qualifies consecutive over-threshold peaks into a sticky alarm.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   enable            sampling enable (tick timer runs while high)
//   threshold[23:0]   alarm threshold, sampled in EVAL only
//   stat_clr          pulse: clear alarm, overrun, sens_err
//   sens              sensor reader handshake (master modport)
//   raw_x/y/z[15:0]   registered raw words driving the scaler
//   scaled_x/y/z[23:0] scaler outputs
//   peak[23:0]        max of scaled x/y/z of the last sample
//   sample_valid      one-cycle pulse when peak updates
//   alarm, overrun, sens_err  sticky status flags
//   busy              high whenever the sequencer is not idle
module quake_sample_ctrl #(
  parameter int SAMPLE_DIV  = 100000,
  parameter int SCALER_LAT  = 2,
  parameter int HITS_REQ    = 3,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [23:0]                threshold,
  input  logic                       stat_clr,
  quake_sample_ctrl_if.master        sens,
  output logic [15:0]                raw_x,
  output logic [15:0]                raw_y,
  output logic [15:0]                raw_z,
  input  logic [23:0]                scaled_x,
  input  logic [23:0]                scaled_y,
  input  logic [23:0]                scaled_z,
  output logic [23:0]                peak,
  output logic                       sample_valid,
  output logic                       alarm,
  output logic                       overrun,
  output logic                       sens_err,
  output logic                       busy
);

  localparam int TW      = $clog2(SAMPLE_DIV);
  localparam int CNT_MAX = (ACK_TIMEOUT > SCALER_LAT) ? ACK_TIMEOUT : SCALER_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [TW-1:0] TICK_RELOAD = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] ACK_LAST    = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(SCALER_LAT - 1);
  localparam logic [3:0]    HITS_SAT    = 4'(HITS_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EVAL
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [CW-1:0] cnt_q;
  logic [3:0]    hits_q, hits_d;
  logic          ack_take, timeout, eval;
  logic [23:0]   max_xy, max_xyz;
  logic          alarm_set;

  // Tick fires on the cycle the down-counter sits at zero, so the first tick
  // lands SAMPLE_DIV edges after enable is first seen high.
  assign tick = enable && (tick_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= TICK_RELOAD;
    end else if (!enable || tick_cnt == '0) begin
      tick_cnt <= TICK_RELOAD;
    end else begin
      tick_cnt <= tick_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ack_take = 1'b0;
    timeout  = 1'b0;
    eval     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_REQ;
      end
      ST_REQ: begin
        // An ack in the last allowed cycle still wins over the timeout.
        if (sens.sens_ack) begin
          state_d  = ST_WAIT;
          ack_take = 1'b1;
        end else if (cnt_q == ACK_LAST) begin
          state_d = ST_IDLE;
          timeout = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        state_d = ST_IDLE;
        eval    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shared dwell counter: counts cycles spent in REQ (timeout) and WAIT
  // (scaler latency); restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_d != state_q || state_q == ST_IDLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    max_xy    = (scaled_x >= scaled_y) ? scaled_x : scaled_y;
    max_xyz   = (max_xy >= scaled_z) ? max_xy : scaled_z;
    hits_d    = hits_q;
    alarm_set = 1'b0;
    if (eval) begin
      if (max_xyz >= threshold) begin
        hits_d = (hits_q == HITS_SAT) ? hits_q : hits_q + 4'd1;
      end else begin
        hits_d = 4'd0;
      end
      alarm_set = (hits_d == HITS_SAT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_x        <= '0;
      raw_y        <= '0;
      raw_z        <= '0;
      peak         <= '0;
      sample_valid <= 1'b0;
      hits_q       <= '0;
      alarm        <= 1'b0;
      overrun      <= 1'b0;
      sens_err     <= 1'b0;
    end else begin
      if (ack_take) begin
        raw_x <= sens.xdata;
        raw_y <= sens.ydata;
        raw_z <= sens.zdata;
      end
      if (eval) peak <= max_xyz;
      sample_valid <= eval;
      hits_q       <= hits_d;
      // Set has priority over a same-cycle clear.
      alarm    <= alarm_set || (alarm && !stat_clr);
      overrun  <= (tick && state_q != ST_IDLE) || (overrun && !stat_clr);
      sens_err <= timeout || (sens_err && !stat_clr);
    end
  end

  // Combinational from state so the request drops with an async reset.
  assign sens.sens_req = (state_q == ST_REQ);
  assign busy          = (state_q != ST_IDLE);

endmodule
